// File: rtl/conv_pkg.sv
// Types and defaults shared between the window generator and the 3x3 convolution stage.
package conv_pkg;

  localparam int SIZE_DEF      = 3;
  localparam int WIDTH_BIT_DEF = 8;

  // Window matrix as seen by the kernel: [row][col][bit], [0][0] = oldest row, leftmost column
  typedef logic [SIZE_DEF-1:0][SIZE_DEF-1:0][WIDTH_BIT_DEF-1:0] win_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/window_gen_line_buffer.sv
// One image line of pixel storage, addressed by column; read-before-write gives the pixel one line back.
module line_buffer #(
  parameter  int DEPTH     = 8,
  parameter  int WIDTH_BIT = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  input  logic [WIDTH_BIT-1:0] din,
  output logic [WIDTH_BIT-1:0] dout
);

  logic [WIDTH_BIT-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // Contents are never cleared: every location is rewritten before it can reach a valid window
  always_ff @(posedge clock) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/window_gen.sv
// Streaming SIZE x SIZE sliding-window generator feeding the convolution stage ("valid"-mode, no padding).
module window_gen #(
  parameter int SIZE      = conv_pkg::SIZE_DEF,
  parameter int WIDTH_BIT = conv_pkg::WIDTH_BIT_DEF,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       pix_valid,
  input  logic [WIDTH_BIT-1:0]                       pix_in,
  output logic                                       pix_ready,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]   win,
  output logic                                       win_valid,
  output logic [$clog2(IMG_H)-1:0]                   win_row,
  output logic [$clog2(IMG_W)-1:0]                   win_col,
  output logic                                       frame_done
);
  import conv_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t                               state, state_nx;
  logic [RW-1:0]                        row, row_nx;
  logic [CW-1:0]                        col;
  logic                                 accept, last_col, last_pix, full;
  logic [WIDTH_BIT-1:0]                 lb_out [SIZE-1];
  logic [SIZE-1:0][WIDTH_BIT-1:0]       new_col;

  assign pix_ready = (state != DONE);
  assign accept    = pix_valid && (state != DONE);
  assign last_col  = (col == CW'(IMG_W-1));
  assign last_pix  = last_col && (row == RW'(IMG_H-1));
  assign row_nx    = last_col ? row + 1'b1 : row;
  assign full      = (row >= RW'(SIZE-1)) && (col >= CW'(SIZE-1));

  // Line buffer j holds the line j+1 rows above the incoming pixel; window row r reads buffer SIZE-2-r
  for (genvar j = 0; j < SIZE-1; j++) begin : g_lb
    logic [WIDTH_BIT-1:0] lb_in;
    if (j == 0) begin : g_head
      assign lb_in = pix_in;
    end else begin : g_chain
      assign lb_in = lb_out[j-1];
    end
    line_buffer #(.DEPTH(IMG_W), .WIDTH_BIT(WIDTH_BIT)) u_lb (
      .clock (clock),
      .en    (accept),
      .addr  (col),
      .din   (lb_in),
      .dout  (lb_out[j])
    );
    assign new_col[SIZE-2-j] = lb_out[j];
  end
  assign new_col[SIZE-1] = pix_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: begin
        if (accept) begin
          if (last_pix)                       state_nx = DONE;
          else if (row_nx >= RW'(SIZE-1))     state_nx = STREAM;
          else                                state_nx = FILL;
        end
      end
    endcase
  end

  // Counters and window register; a stall holds everything except win_valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= accept && full;
      if (accept) begin
        win_row <= row;
        win_col <= col;
        if (last_col) begin
          col <= '0;
          row <= last_pix ? '0 : row_nx;
        end else begin
          col <= col + 1'b1;
        end
        for (int r = 0; r < SIZE; r++) begin
          for (int c = 0; c < SIZE-1; c++) win[r][c] <= win[r][c+1];
          win[r][SIZE-1] <= new_col[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on a 4x4 image with a 3x3 window.
module tb_window_gen;
  localparam int SIZE = 3;
  localparam int WB   = 8;
  localparam int IW   = 4;
  localparam int IH   = 4;

  typedef logic [SIZE-1:0][SIZE-1:0][WB-1:0] w_t;

  typedef struct {
    logic       vld;
    logic [7:0] pix;
    logic       wv;
    logic       fd;
    logic       rdy;
    logic       cw;
    w_t         w;
    logic [1:0] row;
    logic [1:0] col;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic       pix_ready;
  w_t         win;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  window_gen #(.SIZE(SIZE), .WIDTH_BIT(WB), .IMG_W(IW), .IMG_H(IH)) dut (
    .clock      (clock),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .pix_ready  (pix_ready),
    .win        (win),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Window whose newest pixel sits at (r_end, c_end) of a frame of pixels base, base+1, ...
  function automatic w_t exp_win(input int base, input int r_end, input int c_end);
    w_t w;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        w[r][c] = 8'(base + (r_end - SIZE + 1 + r) * IW + (c_end - SIZE + 1 + c));
    return w;
  endfunction

  task automatic add_frame(input int base);
    for (int i = 0; i < IW*IH; i++) begin
      vec_t v;
      int rr, cc;
      rr    = i / IW;
      cc    = i % IW;
      v.vld = 1'b1;
      v.pix = 8'(base + i);
      v.wv  = (rr >= SIZE-1) && (cc >= SIZE-1);
      v.fd  = (i == IW*IH-1);
      v.rdy = (i != IW*IH-1);
      v.cw  = v.wv;
      v.w   = exp_win(base, rr, cc);
      v.row = 2'(rr);
      v.col = 2'(cc);
      tbl.push_back(v);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too
  task automatic step(input logic v, input logic [7:0] p);
    pix_valid = v;
    pix_in    = p;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t rej;
    int   nwin, wins, fds;

    // Two back-to-back frames with pixel 100 held valid across the DONE cycle
    add_frame(0);
    rej.vld = 1'b1; rej.pix = 8'd100; rej.wv = 1'b0; rej.fd = 1'b0; rej.rdy = 1'b1;
    rej.cw = 1'b1; rej.w = exp_win(0, 3, 3); rej.row = 2'd0; rej.col = 2'd0;
    tbl.push_back(rej);
    add_frame(100);

    #2;
    chk("rst_win", 72'(win), 72'(0));
    chk("rst_wv", 72'(win_valid), 72'(0));
    chk("rst_fd", 72'(frame_done), 72'(0));
    chk("rst_rdy", 72'(pix_ready), 72'(1));
    #10 reset = 1'b0;
    @(posedge clock);
    #1;

    nwin = 0;
    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].pix);
      chk($sformatf("t%0d_wv", i), 72'(win_valid), 72'(tbl[i].wv));
      chk($sformatf("t%0d_fd", i), 72'(frame_done), 72'(tbl[i].fd));
      chk($sformatf("t%0d_rdy", i), 72'(pix_ready), 72'(tbl[i].rdy));
      if (tbl[i].cw) chk($sformatf("t%0d_win", i), 72'(win), 72'(tbl[i].w));
      if (tbl[i].wv) begin
        chk($sformatf("t%0d_row", i), 72'(win_row), 72'(tbl[i].row));
        chk($sformatf("t%0d_col", i), 72'(win_col), 72'(tbl[i].col));
      end
      if (win_valid) nwin++;
      if (i == 10) begin
        chk("first_w00", 72'(win[0][0]), 72'(0));
        chk("first_w12", 72'(win[1][2]), 72'(6));
        chk("first_w22", 72'(win[2][2]), 72'(10));
      end
      if (i == 15) begin
        chk("last_w00", 72'(win[0][0]), 72'(5));
        chk("last_w22", 72'(win[2][2]), 72'(15));
      end
      if (i == 27) begin
        chk("f2_first_w00", 72'(win[0][0]), 72'(100));
        chk("f2_first_w22", 72'(win[2][2]), 72'(110));
      end
    end
    chk("table_win_count", 72'(nwin), 72'(8));

    // Frame with random idle gaps between pixels
    step(1'b0, 8'd0);
    chk("gap_pre_fd", 72'(frame_done), 72'(0));
    chk("gap_pre_rdy", 72'(pix_ready), 72'(1));
    wins = 0;
    fds  = 0;
    for (int k = 0; k < IW*IH; k++) begin
      int g, rr, cc;
      logic ev;
      g = $urandom_range(0, 2);
      for (int s = 0; s < g; s++) begin
        step(1'b0, 8'hEE);
        chk($sformatf("gap%0d_idle_wv", k), 72'(win_valid), 72'(0));
        chk($sformatf("gap%0d_idle_fd", k), 72'(frame_done), 72'(0));
      end
      rr = k / IW;
      cc = k % IW;
      ev = (rr >= SIZE-1) && (cc >= SIZE-1);
      step(1'b1, 8'(200 + k));
      chk($sformatf("gap%0d_wv", k), 72'(win_valid), 72'(ev));
      if (ev) chk($sformatf("gap%0d_win", k), 72'(win), 72'(exp_win(200, rr, cc)));
      if (win_valid) wins++;
      if (frame_done) fds++;
    end
    chk("gap_win_count", 72'(wins), 72'(4));
    chk("gap_fd_count", 72'(fds), 72'(1));

    // Abort a frame with an asynchronous reset, then run a fresh frame
    step(1'b0, 8'd0);
    for (int k = 0; k <= 10; k++) step(1'b1, 8'(50 + k));
    chk("pre_rst_wv", 72'(win_valid), 72'(1));
    pix_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_win", 72'(win), 72'(0));
    chk("async_rst_wv", 72'(win_valid), 72'(0));
    chk("async_rst_fd", 72'(frame_done), 72'(0));
    chk("async_rst_rdy", 72'(pix_ready), 72'(1));
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    wins = 0;
    fds  = 0;
    for (int k = 0; k < IW*IH; k++) begin
      int rr, cc;
      rr = k / IW;
      cc = k % IW;
      step(1'b1, 8'(150 + k));
      if (win_valid) begin
        wins++;
        chk($sformatf("post_rst%0d_win", k), 72'(win), 72'(exp_win(150, rr, cc)));
      end
      if (frame_done) fds++;
    end
    step(1'b0, 8'd0);
    if (frame_done) fds++;
    chk("post_rst_win_count", 72'(wins), 72'(4));
    chk("post_rst_fd_count", 72'(fds), 72'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Streaming 2-D sliding-window generator; sits directly upstream of the 3x3 convolution stage.
- Accepts one raster-order pixel per cycle, buffers SIZE-1 previous image lines and presents a registered SIZE x SIZE window plus a valid strobe.
- Valid drives the convolution enable; the window array drives its matrix input with [row][col] indexing identical to the kernel's.
- No padding: only fully-populated ("valid"-mode) windows are emitted.

Parameters:
- SIZE, 3, window edge length; must be >= 2 and <= IMG_W, IMG_H.
- WIDTH_BIT, 8, pixel width in bits.
- IMG_W, 8, image width in pixels.
- IMG_H, 8, image height in pixels.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  pix_in carries a pixel this cycle
- pix_in  in  WIDTH_BIT  raster-order pixel, row-major, left to right
- pix_ready  out  1  block accepts a pixel this cycle; a pixel is accepted when pix_valid && pix_ready
- win  out  [WIDTH_BIT-1:0] x [SIZE-1:0][SIZE-1:0]  window; [0][0] = oldest row, leftmost column; [SIZE-1][SIZE-1] = newest pixel
- win_valid  out  1  win holds a complete window (drives convolution enable)
- win_row  out  $clog2(IMG_H)  image row of win[SIZE-1][SIZE-1]
- win_col  out  $clog2(IMG_W)  image column of win[SIZE-1][SIZE-1]
- frame_done  out  1  one-cycle pulse after the last window of a frame

Behaviour:
- Reset (async assert, sync release): state IDLE; row/col counters 0; win all zeros; win_valid, frame_done 0; win_row, win_col 0; pix_ready 1. Line-buffer RAM is not cleared; it is never read into a valid window before being rewritten.
- States:
  - IDLE: waiting for the first pixel of a frame. First accepted pixel -> FILL (or STREAM if SIZE-1 = 0 rows is impossible, so always FILL).
  - FILL: row < SIZE-1.
  - STREAM: row >= SIZE-1.
  - DONE: one cycle; frame_done=1, pix_ready=0; -> IDLE.
- Per accepted pixel:
  - Each window row r < SIZE-1 shifts left, taking line-buffer output for line r at the current column.
  - Row SIZE-1 shifts in pix_in.
  - Line buffers shift down one line at the current column.
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
- Window valid rule: win_valid is registered 1 in the cycle after an accepted pixel with row >= SIZE-1 and col >= SIZE-1, otherwise 0. Latency from that accepted pixel to win_valid is exactly 1 cycle.
- win_row and win_col register the row/col of that pixel.
- Stall: cycles with pix_valid=0 hold all state; win_valid drops to 0 and win holds its last value.
- Row wrap: the first SIZE-1 pixels of every row never raise win_valid, even though the window still contains stale columns from the previous row.
- Last pixel (row IMG_H-1, col IMG_W-1):
  - Counters return to 0 and the state goes to DONE.
  - The final win_valid and frame_done assert in the same cycle.
  - Any pixel presented during DONE is not accepted (pix_ready=0).
- Reset mid-frame aborts the frame: no frame_done; the next accepted pixel is treated as (0,0).
- Window count per frame: exactly (IMG_H-SIZE+1)*(IMG_W-SIZE+1).
- Pixels are passed through unmodified; no arithmetic or width change.

Decomposition:
- Shared package conv_pkg:
  - SIZE and WIDTH_BIT defaults.
  - Window array typedef, shared by this block and the convolution stage.
  - State enum {IDLE, FILL, STREAM, DONE}.
- One sub-module line_buffer:
  - IMG_W-deep, WIDTH_BIT-wide shift/RAM line with enable.
  - Instantiated SIZE-1 times, chained.

Test Plan:
- Reset/idle: reset=1 mid-stream -> win all 0, win_valid=0, frame_done=0, pix_ready=1 immediately (async), without a clock edge.
- Basic 4x4 frame (IMG_W=IMG_H=4, SIZE=3), pixels 0..15 back-to-back:
  - win_valid high exactly 4 times, 1 cycle after pixels 10, 11, 14, 15.
  - First window {0,1,2},{4,5,6},{8,9,10} with win_row=2, win_col=2.
  - Last window {5,6,7},{9,10,11},{13,14,15}, with frame_done=1 in the same cycle.
- Row wrap: in the same frame, the cycles after pixels 12 and 13 -> win_valid=0.
- Random pix_valid gaps (~50%) on the 4x4 frame -> identical window sequence and values to the back-to-back case; win_valid never asserted on a cycle that does not follow an accepted pixel.
- DONE cycle: pix_valid held 1 across the frame boundary -> pix_ready=0 for exactly one cycle after pixel 15. The next frame's first pixel (e.g. 100) is accepted the following cycle, and its first window equals {100,101,102},{104,105,106},{108,109,110} for 100..115 input.
- Reset mid-frame: reset after pixel 9, then stream a fresh 16-pixel frame -> exactly 4 windows, none containing pre-reset data, and one frame_done.
